// File: rtl/micro_sequencer_pkg.sv
// Shared types for the CtrlPIM microprogram sequencer: FSM states, microword
// field layout and an unpack helper.
package useq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, EXEC} state_e;

  localparam int END_BIT  = 31;
  localparam int JMP_BIT  = 30;
  localparam int REP_LSB  = 26;
  localparam int REP_W    = 4;
  localparam int TGT_LSB  = 16;
  localparam int TGT_W    = 10;
  localparam int CTRL_LSB = 0;
  localparam int CTRL_W   = 16;

  typedef struct packed {
    logic              is_end;
    logic              jump;
    logic [REP_W-1:0]  rep;
    logic [TGT_W-1:0]  target;
    logic [CTRL_W-1:0] ctrl;
  } uword_t;

  function automatic uword_t unpack_uword(input logic [31:0] w);
    uword_t u;
    u.is_end = w[END_BIT];
    u.jump   = w[JMP_BIT];
    u.rep    = w[REP_LSB +: REP_W];
    u.target = w[TGT_LSB +: TGT_W];
    u.ctrl   = w[CTRL_LSB +: CTRL_W];
    return u;
  endfunction

endpackage

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks an external synchronous microcode ROM from a
// dispatched entry address and issues control payloads over valid/ready.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int UROM_DEPTH = 256,
  parameter int UWORD_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dispatch_valid,
  input  logic [ADDR_W-1:0]  dispatch_addr,
  output logic               dispatch_ready,
  output logic               urom_rd,
  output logic [ADDR_W-1:0]  urom_addr,
  input  logic [UWORD_W-1:0] urom_data,
  output logic               uop_valid,
  input  logic               uop_ready,
  output logic [15:0]        uop_ctrl,
  input  logic               abort,
  output logic               done,
  output logic               aborted,
  output logic               err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(UROM_DEPTH);

  state_e             state_q;
  logic [ADDR_W-1:0]  upc_q;
  logic [UWORD_W-1:0] uword_q;
  logic [REP_W-1:0]   rep_cnt_q;
  logic               done_q, aborted_q, err_q;

  uword_t             uw, rom_uw;
  logic [ADDR_W:0]    upc_inc;
  logic [ADDR_W-1:0]  tgt, nxt_upc;
  logic               nxt_bad, disp_bad;

  assign uw      = unpack_uword(uword_q[31:0]);
  assign rom_uw  = unpack_uword(urom_data[31:0]);
  assign upc_inc = {1'b0, upc_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign tgt     = {{(ADDR_W-TGT_W){1'b0}}, uw.target};
  assign nxt_upc = uw.jump ? tgt : upc_inc[ADDR_W-1:0];
  // A sequential step that carries out of ADDR_W is illegal even if it wraps low.
  assign nxt_bad  = (!uw.jump && upc_inc[ADDR_W]) || ({1'b0, nxt_upc} >= DEPTH_L);
  assign disp_bad = {1'b0, dispatch_addr} >= DEPTH_L;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      upc_q     <= '0;
      uword_q   <= '0;
      rep_cnt_q <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      // abort outranks everything outside IDLE, including a same-cycle handshake
      if (abort && state_q != IDLE) begin
        aborted_q <= 1'b1;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (dispatch_valid) begin
            if (disp_bad) err_q <= 1'b1;
            else begin
              upc_q   <= dispatch_addr;
              state_q <= FETCH;
            end
          end
          FETCH: state_q <= LOAD;
          LOAD: begin
            uword_q   <= urom_data;
            rep_cnt_q <= rom_uw.rep;
            state_q   <= EXEC;
          end
          EXEC: if (uop_ready) begin
            if (rep_cnt_q != '0) rep_cnt_q <= rep_cnt_q - 1'b1;
            else if (uw.is_end) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else if (nxt_bad) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              upc_q   <= nxt_upc;
              state_q <= FETCH;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dispatch_ready = (state_q == IDLE);
  assign urom_rd        = (state_q == FETCH);
  assign urom_addr      = upc_q;
  assign uop_valid      = (state_q == EXEC);
  assign uop_ctrl       = uw.ctrl;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign err            = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: table of routines with a ctrl
// scoreboard, plus hand sequences for timing, abort and reset.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic [15:0] dispatch_addr = '0;
  logic        dispatch_ready;
  logic        urom_rd;
  logic [15:0] urom_addr;
  logic [31:0] urom_data = '0;
  logic        uop_valid;
  logic        uop_ready = 1'b1;
  logic [15:0] uop_ctrl;
  logic        abort = 1'b0;
  logic        done, aborted, err;

  micro_sequencer #(.ADDR_W(16), .UROM_DEPTH(256), .UWORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_addr(dispatch_addr),
    .dispatch_ready(dispatch_ready),
    .urom_rd(urom_rd), .urom_addr(urom_addr), .urom_data(urom_data),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_ctrl(uop_ctrl),
    .abort(abort), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  logic [31:0] rom [256];
  logic [15:0] exp_q[$];
  logic [15:0] rd_addr[$];
  int rd_cyc[$], hs_cyc[$];
  int t_disp, done_cyc, n_hs, n_done, n_err, n_ab;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input bit e, input bit j, input int rep,
                                      input int tgt, input logic [15:0] c);
    logic [3:0] r = 4'(rep);
    logic [9:0] t = 10'(tgt);
    return {e, j, r, t, c};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (urom_rd) urom_data <= (urom_addr < 16'd256) ? rom[urom_addr[7:0]] : 32'hDEAD_DEAD;
  end

  // Monitor: logs reads/handshakes/pulses and pops the ctrl scoreboard.
  always @(negedge clk) if (rst_n) begin
    if (dispatch_valid && dispatch_ready) t_disp = cyc;
    if (urom_rd) begin
      rd_addr.push_back(urom_addr);
      rd_cyc.push_back(cyc);
      if (urom_addr >= 16'd256) chk("illegal_rom_read", 32'(urom_addr), 32'hFF);
    end
    if (uop_valid && uop_ready) begin
      hs_cyc.push_back(cyc);
      n_hs++;
      if (exp_q.size() == 0) chk("uop_unexpected", 32'(uop_ctrl), 32'hFFFF_FFFF);
      else chk("uop_ctrl", 32'(uop_ctrl), 32'(exp_q.pop_front()));
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) n_err++;
    if (aborted) n_ab++;
  end

  typedef struct {
    logic [15:0]      addr;
    int               n;
    logic [3:0][15:0] c;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  function automatic vec_t mkv(input logic [15:0] a, input int n, input logic [63:0] c,
                               input bit d, input bit e);
    vec_t v;
    v.addr = a; v.n = n; v.c = c; v.exp_done = d; v.exp_err = e;
    return v;
  endfunction

  task automatic clear_logs();
    rd_addr.delete(); rd_cyc.delete(); hs_cyc.delete(); exp_q.delete();
    n_hs = 0; n_done = 0; n_err = 0; n_ab = 0; t_disp = -1; done_cyc = -1;
  endtask

  task automatic dispatch(input logic [15:0] a);
    @(posedge clk); #1;
    dispatch_valid = 1'b1; dispatch_addr = a;
    @(posedge clk); #1;
    dispatch_valid = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk); #1;
      if (done || err || aborted) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = mkw(1, 0, 0, 0, 16'hEEEE);
    rom[8'h06] = mkw(0, 0, 0, 0, 16'h00A1);
    rom[8'h07] = mkw(1, 0, 0, 0, 16'h00B2);
    rom[8'h26] = mkw(1, 0, 3, 0, 16'h0011);
    rom[8'h36] = mkw(0, 1, 0, 16'h56, 16'h0036);
    rom[8'h37] = mkw(1, 0, 0, 0, 16'hDEAD);
    rom[8'h56] = mkw(1, 0, 0, 0, 16'h0056);
    rom[8'hFF] = mkw(0, 0, 0, 0, 16'h00FF);
    rom[8'h40] = mkw(0, 1, 0, 16'h3FF, 16'h0040);
    rom[8'h50] = mkw(1, 1, 0, 16'h10, 16'h0050);
    rom[8'h60] = mkw(0, 1, 1, 16'h62, 16'h0060);
    rom[8'h62] = mkw(1, 0, 0, 0, 16'h0062);
    rom[8'h70] = mkw(1, 0, 0, 0, 16'h0070);

    vecs[0] = mkv(16'h0006, 2, {16'h0, 16'h0, 16'h00B2, 16'h00A1}, 1, 0);
    vecs[1] = mkv(16'h0026, 4, {16'h0011, 16'h0011, 16'h0011, 16'h0011}, 1, 0);
    vecs[2] = mkv(16'h0036, 2, {16'h0, 16'h0, 16'h0056, 16'h0036}, 1, 0);
    vecs[3] = mkv(16'h00FF, 1, {16'h0, 16'h0, 16'h0, 16'h00FF}, 0, 1);
    vecs[4] = mkv(16'h0040, 1, {16'h0, 16'h0, 16'h0, 16'h0040}, 0, 1);
    vecs[5] = mkv(16'h0050, 1, {16'h0, 16'h0, 16'h0, 16'h0050}, 1, 0);
    vecs[6] = mkv(16'h0060, 3, {16'h0, 16'h0062, 16'h0060, 16'h0060}, 1, 0);
    vecs[7] = mkv(16'h0100, 0, 64'h0, 0, 1);
    vecs[8] = mkv(16'hFFFF, 0, 64'h0, 0, 1);

    clear_logs();
    #12;
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_uop_valid", 32'(uop_valid), 32'd0);
    chk("rst_urom_rd", 32'(urom_rd), 32'd0);
    chk("rst_pulses", {29'd0, done, aborted, err}, 32'd0);
    chk("rst_upc", 32'(urom_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      clear_logs();
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].c[k]);
      dispatch(vecs[i].addr);
      wait_end($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_handshakes", i), 32'(n_hs), 32'(vecs[i].n));
      chk($sformatf("vec%0d_done", i), 32'(n_done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_err", i), 32'(n_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ready_after", i), 32'(dispatch_ready), 32'd1);
      case (i)
        0: begin
          chk("v0_rd_at_T+1", 32'(rd_cyc.size() > 0 ? rd_cyc[0] - t_disp : -1), 32'd1);
          chk("v0_uop0_at_T+3", 32'(hs_cyc.size() > 0 ? hs_cyc[0] - t_disp : -1), 32'd3);
          chk("v0_uop1_at_T+6", 32'(hs_cyc.size() > 1 ? hs_cyc[1] - t_disp : -1), 32'd6);
          chk("v0_done_at_T+7", 32'(done_cyc - t_disp), 32'd7);
        end
        1: chk("v1_back_to_back", 32'(hs_cyc.size() == 4 ? hs_cyc[3] - hs_cyc[0] : -1), 32'd3);
        2: begin
          chk("v2_rd_count", 32'(rd_addr.size()), 32'd2);
          chk("v2_rd0", 32'(rd_addr.size() > 0 ? rd_addr[0] : 16'hFFFF), 32'h36);
          chk("v2_rd1", 32'(rd_addr.size() > 1 ? rd_addr[1] : 16'hFFFF), 32'h56);
        end
        3: chk("v3_no_read_0x100", 32'(rd_addr.size()), 32'd1);
        7: chk("v7_no_read", 32'(rd_addr.size()), 32'd0);
        default: ;
      endcase
    end

    // Stall 5 cycles in EXEC, then abort.
    begin
      logic [15:0] c0;
      bit stable = 1, got = 0;
      clear_logs();
      uop_ready = 1'b0;
      dispatch(16'h0070);
      for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); #1; got = uop_valid; end
      chk("abort_reached_exec", 32'(got), 32'd1);
      c0 = uop_ctrl;
      chk("abort_ctrl", 32'(c0), 32'h70);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        if (!uop_valid || uop_ctrl !== c0) stable = 0;
      end
      chk("stall_stable", 32'(stable), 32'd1);
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk); #1;
      chk("aborted_pulse", 32'(n_ab), 32'd1);
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_idle", {30'd0, dispatch_ready, uop_valid}, 32'd2);
      uop_ready = 1'b1;
    end

    // Abort in IDLE is ignored and a same-cycle dispatch is taken.
    clear_logs();
    for (int k = 0; k < 4; k++) exp_q.push_back(16'h0011);
    @(posedge clk); #1;
    abort = 1'b1; dispatch_valid = 1'b1; dispatch_addr = 16'h0026;
    @(posedge clk); #1;
    abort = 1'b0; dispatch_valid = 1'b0;
    wait_end("idle_abort");
    chk("idle_abort_done", 32'(n_done), 32'd1);
    chk("idle_abort_no_aborted", 32'(n_ab), 32'd0);
    chk("idle_abort_hs", 32'(n_hs), 32'd4);

    // Reset during a repeat burst.
    begin
      bit got = 0;
      clear_logs();
      for (int k = 0; k < 4; k++) exp_q.push_back(16'h0011);
      dispatch(16'h0026);
      for (int k = 0; k < 10 && !got; k++) begin @(negedge clk); #1; got = (n_hs >= 1); end
      chk("rst_burst_started", 32'(got), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_uop_valid", 32'(uop_valid), 32'd0);
      chk("rst_async_pulses", {29'd0, done, aborted, err}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_rel_ready", 32'(dispatch_ready), 32'd1);
      chk("rst_rel_upc", 32'(urom_addr), 32'd0);
      chk("rst_rel_uop_valid", 32'(uop_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
